// File: rtl/matmul_seq_ctrl.sv
// Sequencing controller for the UART matrix multiplier: header/operand loading, multiplier launch, result streaming.
// Define MATMUL_SEQ_CTRL_TIMEOUT_EN to abort a stalled receive after TIMEOUT_CYCLES idle cycles.
module matmul_seq_ctrl #(
    parameter int MAX_DIM        = 8,
    parameter int RES_BYTES      = 2,
    parameter int TIMEOUT_CYCLES = 1_000_000,
    localparam int AW            = $clog2(MAX_DIM * MAX_DIM)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx_valid,
    input  logic [7:0]             rx_data,
    input  logic                   tx_busy,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    output logic                   a_we,
    output logic                   b_we,
    output logic [AW-1:0]          wr_addr,
    output logic [7:0]             wr_data,
    output logic                   mult_start,
    input  logic                   mult_done,
    output logic [3:0]             dim_m,
    output logic [3:0]             dim_k,
    output logic [3:0]             dim_n,
    output logic [AW-1:0]          res_raddr,
    input  logic [8*RES_BYTES-1:0] res_data,
    output logic                   busy,
    output logic                   err,
    output logic [3:0]             state
);

    localparam int PW = AW + 1;
    localparam int RW = 8 * RES_BYTES;

    if (MAX_DIM < 2 || MAX_DIM > 15) begin : g_bad_max_dim
        $error("MAX_DIM must be in 2..15");
    end
    if (RES_BYTES < 1 || RES_BYTES > 4) begin : g_bad_res_bytes
        $error("RES_BYTES must be in 1..4");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_GET_K     = 4'd1,
        S_GET_N     = 4'd2,
        S_LOAD_A    = 4'd3,
        S_LOAD_B    = 4'd4,
        S_START     = 4'd5,
        S_COMPUTE   = 4'd6,
        S_FETCH     = 4'd7,
        S_FETCH_LAT = 4'd8,
        S_SEND      = 4'd9,
        S_TX_WAIT   = 4'd10,
        S_ERROR     = 4'd11
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      dim_m_q, dim_m_d, dim_k_q, dim_k_d, dim_n_q, dim_n_d;
    logic            bad_q, bad_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [1:0]      bidx_q, bidx_d;
    logic [RW-1:0]   shift_q, shift_d;
    logic            err_job_q, err_job_d;
    logic            guard_q, guard_d;
    logic            tx_start_q, tx_start_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            mult_start_q, mult_start_d;
    logic [AW-1:0]   res_raddr_q, res_raddr_d;
    logic            err_q, err_d;
`ifdef MATMUL_SEQ_CTRL_TIMEOUT_EN
    logic [31:0]     idle_cnt_q, idle_cnt_d;
`endif

    logic [PW-1:0]   mk, kn, mn;
    logic            a_last, b_last, res_last, elem_done;

    // Products are one bit wider than the address so MAX_DIM*MAX_DIM never wraps.
    assign mk = PW'(dim_m_q) * PW'(dim_k_q);
    assign kn = PW'(dim_k_q) * PW'(dim_n_q);
    assign mn = PW'(dim_m_q) * PW'(dim_n_q);

    assign a_last    = ({1'b0, cnt_q} == mk - PW'(1));
    assign b_last    = ({1'b0, cnt_q} == kn - PW'(1));
    assign res_last  = ({1'b0, cnt_q} == mn - PW'(1));
    assign elem_done = (bidx_q == 2'(RES_BYTES - 1));

    function automatic logic dim_bad(input logic [7:0] v);
        return (v == 8'd0) || (v > 8'(MAX_DIM));
    endfunction

    always_comb begin
        state_d      = state_q;
        dim_m_d      = dim_m_q;
        dim_k_d      = dim_k_q;
        dim_n_d      = dim_n_q;
        bad_d        = bad_q;
        cnt_d        = cnt_q;
        bidx_d       = bidx_q;
        shift_d      = shift_q;
        err_job_d    = err_job_q;
        guard_d      = guard_q;
        tx_start_d   = 1'b0;
        tx_data_d    = tx_data_q;
        mult_start_d = 1'b0;
        res_raddr_d  = res_raddr_q;
        err_d        = err_q;
        case (state_q)
            S_IDLE: if (rx_valid) begin
                dim_m_d = rx_data[3:0];
                bad_d   = dim_bad(rx_data);
                err_d   = 1'b0;
                state_d = S_GET_K;
            end
            S_GET_K: if (rx_valid) begin
                dim_k_d = rx_data[3:0];
                bad_d   = bad_q | dim_bad(rx_data);
                state_d = S_GET_N;
            end
            S_GET_N: if (rx_valid) begin
                dim_n_d = rx_data[3:0];
                cnt_d   = '0;
                state_d = (bad_q || dim_bad(rx_data)) ? S_ERROR : S_LOAD_A;
            end
            S_LOAD_A: if (rx_valid) begin
                if (a_last) begin
                    cnt_d   = '0;
                    state_d = S_LOAD_B;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            S_LOAD_B: if (rx_valid) begin
                if (b_last) begin
                    // Raise the start pulse on the transition so it is visible during START.
                    cnt_d        = '0;
                    mult_start_d = 1'b1;
                    state_d      = S_START;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            S_START: state_d = S_COMPUTE;
            S_COMPUTE: if (mult_done) begin
                cnt_d       = '0;
                res_raddr_d = '0;
                state_d     = S_FETCH;
            end
            S_FETCH: state_d = S_FETCH_LAT;
            S_FETCH_LAT: begin
                shift_d   = res_data;
                bidx_d    = 2'd0;
                err_job_d = 1'b0;
                state_d   = S_SEND;
            end
            S_SEND: if (!tx_busy) begin
                tx_start_d = 1'b1;
                tx_data_d  = shift_q[RW-1 -: 8];
                guard_d    = 1'b1;
                state_d    = S_TX_WAIT;
            end
            S_TX_WAIT: begin
                // The first cycle after tx_start ignores tx_busy, which may not have risen yet.
                if (guard_q) begin
                    guard_d = 1'b0;
                end else if (!tx_busy) begin
                    if (!elem_done) begin
                        bidx_d  = bidx_q + 2'd1;
                        shift_d = shift_q << 8;
                        state_d = S_SEND;
                    end else if (err_job_q || res_last) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d       = cnt_q + AW'(1);
                        res_raddr_d = cnt_q + AW'(1);
                        state_d     = S_FETCH;
                    end
                end
            end
            S_ERROR: begin
                err_d             = 1'b1;
                err_job_d         = 1'b1;
                shift_d           = '0;
                shift_d[RW-1 -: 8] = 8'hEE;
                bidx_d            = 2'(RES_BYTES - 1);
                state_d           = S_SEND;
            end
            default: state_d = S_IDLE;
        endcase
`ifdef MATMUL_SEQ_CTRL_TIMEOUT_EN
        idle_cnt_d = '0;
        if ((state_q inside {S_GET_K, S_GET_N, S_LOAD_A, S_LOAD_B}) && !rx_valid) begin
            if (idle_cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
                state_d = S_ERROR;
            end else begin
                idle_cnt_d = idle_cnt_q + 32'd1;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            dim_m_q      <= '0;
            dim_k_q      <= '0;
            dim_n_q      <= '0;
            bad_q        <= 1'b0;
            cnt_q        <= '0;
            bidx_q       <= '0;
            shift_q      <= '0;
            err_job_q    <= 1'b0;
            guard_q      <= 1'b0;
            tx_start_q   <= 1'b0;
            tx_data_q    <= '0;
            mult_start_q <= 1'b0;
            res_raddr_q  <= '0;
            err_q        <= 1'b0;
`ifdef MATMUL_SEQ_CTRL_TIMEOUT_EN
            idle_cnt_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            dim_m_q      <= dim_m_d;
            dim_k_q      <= dim_k_d;
            dim_n_q      <= dim_n_d;
            bad_q        <= bad_d;
            cnt_q        <= cnt_d;
            bidx_q       <= bidx_d;
            shift_q      <= shift_d;
            err_job_q    <= err_job_d;
            guard_q      <= guard_d;
            tx_start_q   <= tx_start_d;
            tx_data_q    <= tx_data_d;
            mult_start_q <= mult_start_d;
            res_raddr_q  <= res_raddr_d;
            err_q        <= err_d;
`ifdef MATMUL_SEQ_CTRL_TIMEOUT_EN
            idle_cnt_q   <= idle_cnt_d;
`endif
        end
    end

    assign a_we       = rx_valid && (state_q == S_LOAD_A);
    assign b_we       = rx_valid && (state_q == S_LOAD_B);
    assign wr_addr    = cnt_q;
    assign wr_data    = rx_data;
    assign tx_start   = tx_start_q;
    assign tx_data    = tx_data_q;
    assign mult_start = mult_start_q;
    assign dim_m      = dim_m_q;
    assign dim_k      = dim_k_q;
    assign dim_n      = dim_n_q;
    assign res_raddr  = res_raddr_q;
    assign busy       = (state_q != S_IDLE);
    assign err        = err_q;
    assign state      = state_q;

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Bench for matmul_seq_ctrl: buffer, multiplier, result RAM and UART tx models with a byte scoreboard.
module tb_matmul_seq_ctrl;

    localparam int RES_BYTES = 2;
    localparam int AW        = 6;
    localparam logic [3:0] ST_IDLE  = 4'd0;
    localparam logic [3:0] ST_GET_K = 4'd1;
    localparam logic [3:0] ST_FETCH = 4'd7;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          tx_busy;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic          a_we, b_we;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          mult_start;
    logic          mult_done = 1'b0;
    logic [3:0]    dim_m, dim_k, dim_n;
    logic [AW-1:0] res_raddr;
    logic [15:0]   res_data;
    logic          busy, err;
    logic [3:0]    state;

    matmul_seq_ctrl #(.MAX_DIM(8), .RES_BYTES(RES_BYTES), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
        .a_we(a_we), .b_we(b_we), .wr_addr(wr_addr), .wr_data(wr_data),
        .mult_start(mult_start), .mult_done(mult_done),
        .dim_m(dim_m), .dim_k(dim_k), .dim_n(dim_n),
        .res_raddr(res_raddr), .res_data(res_data),
        .busy(busy), .err(err), .state(state)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_q[$];

    logic [7:0]  a_mem[64];
    logic [7:0]  b_mem[64];
    logic [15:0] res_mem[64];
    int          a_v[64];
    int          b_v[64];
    int          job_m = 0, job_k = 0, job_n = 0;
    int          a_we_cnt = 0, b_we_cnt = 0, a_addr_exp = 0, b_addr_exp = 0;
    int          raddr_exp = 0, mult_starts = 0, tx_count = 0;
    int          busy_len = 2;
    int          busy_cnt;
    logic        prev_tx_start = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // UART transmitter: busy for busy_len cycles after each accepted tx_start.
    always @(posedge clk or posedge rst) begin
        if (rst) busy_cnt <= 0;
        else if (tx_start) busy_cnt <= busy_len;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt > 0);

    always @(posedge clk) res_data <= res_mem[res_raddr];

    always @(negedge clk) begin
        if (!rst) begin
            if (tx_start) begin
                check_eq("tx_start_while_busy", 32'(tx_busy), 0);
                check_eq("tx_start_back_to_back", 32'(prev_tx_start), 0);
                check_eq("tx_byte_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) check_eq("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
                tx_count++;
            end
            if (a_we) begin
                check_eq("a_addr", 32'(wr_addr), a_addr_exp);
                a_mem[wr_addr] = wr_data;
                a_addr_exp++;
                a_we_cnt++;
            end
            if (b_we) begin
                check_eq("b_addr", 32'(wr_addr), b_addr_exp);
                b_mem[wr_addr] = wr_data;
                b_addr_exp++;
                b_we_cnt++;
            end
            if (mult_start) mult_starts++;
            if (state == ST_FETCH) begin
                check_eq("res_raddr", 32'(res_raddr), raddr_exp);
                raddr_exp++;
            end
        end
        prev_tx_start = tx_start;
    end

    // Multiplier core: multiplies whatever landed in the buffers, then pulses mult_done.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && mult_start) begin
                for (int i = 0; i < job_m; i++) begin
                    for (int j = 0; j < job_n; j++) begin
                        int s;
                        s = 0;
                        for (int kk = 0; kk < job_k; kk++)
                            s += int'(a_mem[i*job_k+kk]) * int'(b_mem[kk*job_n+j]);
                        res_mem[i*job_n+j] = 16'(s);
                    end
                end
                repeat (3) @(posedge clk);
                #1 mult_done = 1'b1;
                @(posedge clk);
                #1 mult_done = 1'b0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        @(posedge clk);
        #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic push_expected(input int m, input int k, input int n);
        for (int i = 0; i < m; i++) begin
            for (int j = 0; j < n; j++) begin
                int s;
                s = 0;
                for (int kk = 0; kk < k; kk++) s += a_v[i*k+kk] * b_v[kk*n+j];
                for (int bb = RES_BYTES - 1; bb >= 0; bb--) exp_q.push_back(8'(s >> (8 * bb)));
            end
        end
    endtask

    task automatic wait_done(input int budget);
        int c = 0;
        while ((exp_q.size() != 0 || busy) && c < budget) begin
            @(negedge clk);
            c++;
        end
        check_eq("job_within_budget", 32'(c < budget), 1);
    endtask

    task automatic clear_counts();
        a_we_cnt = 0; b_we_cnt = 0; a_addr_exp = 0; b_addr_exp = 0;
        raddr_exp = 0; mult_starts = 0; tx_count = 0;
    endtask

    task automatic run_job(input int m, input int k, input int n);
        job_m = m; job_k = k; job_n = n;
        clear_counts();
        push_expected(m, k, n);
        send_byte(8'(m));
        check_eq("err_cleared", 32'(err), 0);
        send_byte(8'(k));
        send_byte(8'(n));
        check_eq("dims", {20'd0, dim_m, dim_k, dim_n}, 32'((m << 8) | (k << 4) | n));
        for (int i = 0; i < m * k; i++) send_byte(8'(a_v[i]));
        for (int i = 0; i < k * n; i++) send_byte(8'(b_v[i]));
        check_eq("mult_start_after_last_b", 32'(mult_start), 1);
        send_byte(8'hAA);
        wait_done(20000);
        check_eq("a_we_count", a_we_cnt, m * k);
        check_eq("b_we_count", b_we_cnt, k * n);
        check_eq("mult_start_count", mult_starts, 1);
        check_eq("res_raddr_count", raddr_exp, m * n);
        check_eq("tx_byte_count", tx_count, m * n * RES_BYTES);
        check_eq("job_end_idle", 32'(state), 32'(ST_IDLE));
    endtask

    task automatic run_bad_header(input logic [7:0] m);
        clear_counts();
        exp_q.push_back(8'hEE);
        send_byte(m);
        send_byte(8'd2);
        send_byte(8'd2);
        wait_done(2000);
        check_eq("err_set", 32'(err), 1);
        check_eq("bad_hdr_no_we", a_we_cnt + b_we_cnt, 0);
        check_eq("bad_hdr_tx_count", tx_count, 1);
        check_eq("bad_hdr_idle", 32'(state), 32'(ST_IDLE));
    endtask

    task automatic fill_random(input int m, input int k, input int n);
        for (int i = 0; i < m * k; i++) a_v[i] = $urandom_range(0, 255);
        for (int i = 0; i < k * n; i++) b_v[i] = $urandom_range(0, 255);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) begin
            a_mem[i] = 8'h00; b_mem[i] = 8'h00; res_mem[i] = 16'h0000;
        end
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_state", 32'(state), 32'(ST_IDLE));
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_tx_start", 32'(tx_start), 0);
        check_eq("rst_mult_start", 32'(mult_start), 0);
        check_eq("rst_err", 32'(err), 0);
        check_eq("rst_res_raddr", 32'(res_raddr), 0);
        check_eq("rst_wr_addr", 32'(wr_addr), 0);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin a_v[i] = i + 1; b_v[i] = i + 5; end
        run_job(2, 2, 2);

        a_v[0] = 1; a_v[1] = 2; a_v[2] = 3; b_v[0] = 4; b_v[1] = 5;
        run_job(3, 1, 2);

        run_bad_header(8'd0);
        run_bad_header(8'd9);

        busy_len = 50;
        fill_random(2, 2, 2);
        run_job(2, 2, 2);
        busy_len = 2;

        // Reset while loading B: the partial job must vanish without a start pulse.
        job_m = 2; job_k = 2; job_n = 2;
        clear_counts();
        fill_random(2, 2, 2);
        send_byte(8'd2); send_byte(8'd2); send_byte(8'd2);
        for (int i = 0; i < 4; i++) send_byte(8'(a_v[i]));
        for (int i = 0; i < 2; i++) send_byte(8'(b_v[i]));
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check_eq("midrst_state", 32'(state), 32'(ST_IDLE));
        check_eq("midrst_busy", 32'(busy), 0);
        @(posedge clk);
        #1;
        check_eq("midrst_mult_start", 32'(mult_start), 0);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        check_eq("midrst_no_mult", mult_starts, 0);
        fill_random(2, 2, 2);
        run_job(2, 2, 2);

        for (int r = 0; r < 3; r++) begin
            int m, k, n;
            m = $urandom_range(2, 8);
            k = $urandom_range(2, 8);
            n = $urandom_range(2, 8);
            busy_len = $urandom_range(0, 4);
            fill_random(m, k, n);
            run_job(m, k, n);
        end
        busy_len = 2;

        clear_counts();
`ifdef MATMUL_SEQ_CTRL_TIMEOUT_EN
        exp_q.push_back(8'hEE);
        send_byte(8'd2);
        wait_done(1000);
        check_eq("timeout_idle", 32'(state), 32'(ST_IDLE));
        check_eq("timeout_err", 32'(err), 1);
        check_eq("timeout_tx_count", tx_count, 1);
`else
        send_byte(8'd2);
        repeat (300) @(posedge clk);
        #1;
        check_eq("no_timeout_state", 32'(state), 32'(ST_GET_K));
        check_eq("no_timeout_tx_count", tx_count, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
